// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates the unified 32x8 memory between the
// instruction-fetch port (read-only) and the data port (read/write).
// Every access is a fixed-length transaction; all outputs are registered.
// Build option: define MEM_ACCESS_CTRL_RR_EN for round-robin arbitration
// (default build: fixed DM-over-IF priority).
module mem_access_ctrl #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              busy,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  inout  logic [DATA_W-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [1:0] RW_LAST = 2'(READ_WAIT);

  state_t            state_q,        state_d;
  logic [1:0]        wait_cnt_q,     wait_cnt_d;
  logic              owner_dm_q,     owner_dm_d;
  logic [DATA_W-1:0] wdata_q,        wdata_d;
  logic [ADDR_W-1:0] mem_address_q,  mem_address_d;
  logic              mem_read_en_q,  mem_read_en_d;
  logic              mem_write_en_q, mem_write_en_d;
  logic              busy_q,         busy_d;
  logic              if_gnt_q,       if_gnt_d;
  logic              if_valid_q,     if_valid_d;
  logic [DATA_W-1:0] if_rdata_q,     if_rdata_d;
  logic              dm_gnt_q,       dm_gnt_d;
  logic              dm_valid_q,     dm_valid_d;
  logic [DATA_W-1:0] dm_rdata_q,     dm_rdata_d;
  logic              grant_dm;

`ifdef MEM_ACCESS_CTRL_RR_EN
  // 1 = DM won the previous arbitration, 0 = IF
  logic last_winner_q, last_winner_d;

  // On a tie the port that did not win last goes first
  always_comb begin
    grant_dm = dm_req && (!if_req || !last_winner_q);
  end
`else
  // Fixed priority: DM always beats IF
  always_comb begin
    grant_dm = dm_req;
  end
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    owner_dm_d     = owner_dm_q;
    wdata_d        = wdata_q;
    mem_address_d  = mem_address_q;
    mem_read_en_d  = mem_read_en_q;
    mem_write_en_d = mem_write_en_q;
    busy_d         = busy_q;
    if_rdata_d     = if_rdata_q;
    dm_rdata_d     = dm_rdata_q;
    if_gnt_d       = 1'b0;
    if_valid_d     = 1'b0;
    dm_gnt_d       = 1'b0;
    dm_valid_d     = 1'b0;
`ifdef MEM_ACCESS_CTRL_RR_EN
    last_winner_d  = last_winner_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          owner_dm_d = grant_dm;
          wait_cnt_d = '0;
          busy_d     = 1'b1;
`ifdef MEM_ACCESS_CTRL_RR_EN
          last_winner_d = grant_dm;
`endif
          if (grant_dm) begin
            dm_gnt_d      = 1'b1;
            mem_address_d = dm_addr;
            if (dm_we) begin
              wdata_d        = dm_wdata;
              mem_write_en_d = 1'b1;
              state_d        = WRITE;
            end else begin
              mem_read_en_d = 1'b1;
              state_d       = READ;
            end
          end else begin
            if_gnt_d      = 1'b1;
            mem_address_d = if_addr;
            mem_read_en_d = 1'b1;
            state_d       = READ;
          end
        end
      end

      READ: begin
        if (wait_cnt_q == RW_LAST) begin
          if (owner_dm_q) begin
            dm_rdata_d = mem_data;
            dm_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem_data;
            if_valid_d = 1'b1;
          end
          mem_read_en_d = 1'b0;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end

      WRITE: begin
        dm_valid_d     = 1'b1;
        mem_write_en_d = 1'b0;
        busy_d         = 1'b0;
        state_d        = IDLE;
      end

      default: begin
        mem_read_en_d  = 1'b0;
        mem_write_en_d = 1'b0;
        busy_d         = 1'b0;
        state_d        = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wait_cnt_q     <= '0;
      owner_dm_q     <= 1'b0;
      wdata_q        <= '0;
      mem_address_q  <= '0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      busy_q         <= 1'b0;
      if_gnt_q       <= 1'b0;
      if_valid_q     <= 1'b0;
      if_rdata_q     <= '0;
      dm_gnt_q       <= 1'b0;
      dm_valid_q     <= 1'b0;
      dm_rdata_q     <= '0;
`ifdef MEM_ACCESS_CTRL_RR_EN
      last_winner_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      owner_dm_q     <= owner_dm_d;
      wdata_q        <= wdata_d;
      mem_address_q  <= mem_address_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_write_en_q <= mem_write_en_d;
      busy_q         <= busy_d;
      if_gnt_q       <= if_gnt_d;
      if_valid_q     <= if_valid_d;
      if_rdata_q     <= if_rdata_d;
      dm_gnt_q       <= dm_gnt_d;
      dm_valid_q     <= dm_valid_d;
      dm_rdata_q     <= dm_rdata_d;
`ifdef MEM_ACCESS_CTRL_RR_EN
      last_winner_q  <= last_winner_d;
`endif
    end
  end

  assign if_gnt       = if_gnt_q;
  assign if_valid     = if_valid_q;
  assign if_rdata     = if_rdata_q;
  assign dm_gnt       = dm_gnt_q;
  assign dm_valid     = dm_valid_q;
  assign dm_rdata     = dm_rdata_q;
  assign busy         = busy_q;
  assign mem_read_en  = mem_read_en_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_address  = mem_address_q;
  // WRITE is the only state with mem_write_en high, so it doubles as bus enable
  assign mem_data     = mem_write_en_q ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: main instance (READ_WAIT=1) with a
// behavioural 32x8 memory, plus READ_WAIT=0 and READ_WAIT=3 instances
// reading a fixed location.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic       if_req, dm_req, dm_we;
  logic [4:0] if_addr, dm_addr;
  logic [7:0] dm_wdata;
  logic       if_gnt, if_valid, dm_gnt, dm_valid, busy;
  logic       mem_read_en, mem_write_en;
  logic [7:0] if_rdata, dm_rdata;
  logic [4:0] mem_address;
  wire  [7:0] mem_data;
  logic [7:0] mem_model [32];

  mem_access_ctrl #(.ADDR_W(5), .DATA_W(8), .READ_WAIT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .busy(busy), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_address(mem_address), .mem_data(mem_data)
  );

  always @(posedge clk) if (mem_write_en) mem_model[mem_address] <= mem_data;
  assign mem_data = mem_read_en ? mem_model[mem_address] : 'z;

  // ---------------- READ_WAIT=0 / 3 instances ----------------
  logic       req_w;
  logic       if_gnt_w0, if_valid_w0, dm_gnt_w0, dm_valid_w0, busy_w0, rd_w0, wr_w0;
  logic [7:0] if_rdata_w0, dm_rdata_w0;
  logic [4:0] addr_w0;
  wire  [7:0] data_w0;
  logic       if_gnt_w3, if_valid_w3, dm_gnt_w3, dm_valid_w3, busy_w3, rd_w3, wr_w3;
  logic [7:0] if_rdata_w3, dm_rdata_w3;
  logic [4:0] addr_w3;
  wire  [7:0] data_w3;

  mem_access_ctrl #(.ADDR_W(5), .DATA_W(8), .READ_WAIT(0)) dut_w0 (
    .clk(clk), .rst(rst),
    .if_req(req_w), .if_addr(5'h19), .if_gnt(if_gnt_w0),
    .if_valid(if_valid_w0), .if_rdata(if_rdata_w0),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(5'h00), .dm_wdata(8'h00),
    .dm_gnt(dm_gnt_w0), .dm_valid(dm_valid_w0), .dm_rdata(dm_rdata_w0),
    .busy(busy_w0), .mem_read_en(rd_w0), .mem_write_en(wr_w0),
    .mem_address(addr_w0), .mem_data(data_w0)
  );
  assign data_w0 = rd_w0 ? ((addr_w0 == 5'h19) ? 8'hFF : 8'h00) : 'z;

  mem_access_ctrl #(.ADDR_W(5), .DATA_W(8), .READ_WAIT(3)) dut_w3 (
    .clk(clk), .rst(rst),
    .if_req(req_w), .if_addr(5'h19), .if_gnt(if_gnt_w3),
    .if_valid(if_valid_w3), .if_rdata(if_rdata_w3),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(5'h00), .dm_wdata(8'h00),
    .dm_gnt(dm_gnt_w3), .dm_valid(dm_valid_w3), .dm_rdata(dm_rdata_w3),
    .busy(busy_w3), .mem_read_en(rd_w3), .mem_write_en(wr_w3),
    .mem_address(addr_w3), .mem_data(data_w3)
  );
  assign data_w3 = rd_w3 ? ((addr_w3 == 5'h19) ? 8'hFF : 8'h00) : 'z;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read and write enables must never be high together
  always @(negedge clk) begin
    check("rd_wr_excl", {31'd0, mem_read_en & mem_write_en}, 32'd0);
    check("gnt_excl",   {31'd0, if_gnt & dm_gnt},            32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] seq;
    int unsigned n_g, n_if;
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; req_w = 1'b0;

    // reset state
    tick();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_en",   {30'd0, mem_read_en, mem_write_en}, 0);
    check("rst_pulses", {28'd0, if_gnt, if_valid, dm_gnt, dm_valid}, 0);
    check("rst_addr", {27'd0, mem_address}, 0);
    check("rst_rdata", {16'd0, if_rdata, dm_rdata}, 0);
    tick();
    rst = 1'b0;

    // DM write 0x35 -> 0x15
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5'h15; dm_wdata = 8'h35;
    tick();
    check("wr_gnt",   {31'd0, dm_gnt}, 1);
    check("wr_en",    {30'd0, mem_write_en, mem_read_en}, 32'h2);
    check("wr_addr",  {27'd0, mem_address}, 32'h15);
    check("wr_data",  {24'd0, mem_data}, 32'h35);
    check("wr_busy",  {31'd0, busy}, 1);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    check("wr_valid", {31'd0, dm_valid}, 1);
    check("wr_done_en", {30'd0, mem_write_en, mem_read_en}, 0);
    check("wr_mem",   {24'd0, mem_model[5'h15]}, 32'h35);
    check("wr_idle",  {31'd0, busy}, 0);

    // DM read 0x15, accepted in the write's valid cycle
    dm_req = 1'b1; dm_addr = 5'h15;
    tick();
    check("rd_gnt",   {31'd0, dm_gnt}, 1);
    check("rd_en1",   {30'd0, mem_read_en, mem_write_en}, 32'h2);
    check("rd_addr",  {27'd0, mem_address}, 32'h15);
    dm_req = 1'b0;
    tick();
    check("rd_en2",   {31'd0, mem_read_en}, 1);
    check("rd_novalid", {31'd0, dm_valid}, 0);
    tick();
    check("rd_valid", {31'd0, dm_valid}, 1);
    check("rd_data",  {24'd0, dm_rdata}, 32'h35);
    check("rd_en_off", {31'd0, mem_read_en}, 0);

    // IF read 0x15
    if_req = 1'b1; if_addr = 5'h15;
    tick();
    check("if_gnt",   {31'd0, if_gnt}, 1);
    if_req = 1'b0;
    tick();
    tick();
    check("if_valid", {31'd0, if_valid}, 1);
    check("if_data",  {24'd0, if_rdata}, 32'h35);
    check("if_dm_hold", {24'd0, dm_rdata}, 32'h35);

    // simultaneous: DM write 0xA5 -> 0x17 wins, IF read 0x17 follows
    if_req = 1'b1; if_addr = 5'h17;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5'h17; dm_wdata = 8'hA5;
    tick();
    check("tie_dm_gnt", {30'd0, dm_gnt, if_gnt}, 32'h2);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    check("tie_dm_valid", {30'd0, dm_valid, if_gnt}, 32'h2);
    tick();
    check("tie_if_gnt", {31'd0, if_gnt}, 1);
    check("tie_if_addr", {27'd0, mem_address}, 32'h17);
    if_req = 1'b0;
    tick();
    tick();
    check("tie_if_valid", {31'd0, if_valid}, 1);
    check("tie_if_data",  {24'd0, if_rdata}, 32'hA5);

    // DM requesting continuously with IF pending
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 5'h15;
    if_req = 1'b1; if_addr = 5'h17;
    seq = '0; n_g = 0; n_if = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dm_gnt || if_gnt) begin
        if (n_g < 3) seq[2 - n_g] = dm_gnt;
        n_g++;
        if (if_gnt) n_if++;
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
    check("hold_ngrants", n_g, 4);
`ifdef MEM_ACCESS_CTRL_RR_EN
    check("hold_seq", {29'd0, seq}, 32'h5);
    check("hold_if_cnt", n_if, 2);
`else
    check("hold_seq", {29'd0, seq}, 32'h7);
    check("hold_if_cnt", n_if, 0);
`endif
    for (int i = 0; i < 10 && busy; i++) tick();
    check("hold_idle", {31'd0, busy}, 0);
    tick();

    // reset during the second READ cycle
    dm_req = 1'b1; dm_addr = 5'h15;
    tick();
    check("rr_gnt", {31'd0, dm_gnt}, 1);
    dm_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_en",    {30'd0, mem_read_en, mem_write_en}, 0);
    check("mid_rst_busy",  {31'd0, busy}, 0);
    check("mid_rst_valid", {31'd0, dm_valid}, 0);
    check("mid_rst_rdata", {24'd0, dm_rdata}, 0);
    rst = 1'b0;
    tick();
    check("post_rst_valid", {31'd0, dm_valid}, 0);
    dm_req = 1'b1; dm_addr = 5'h17;
    tick();
    check("fresh_gnt", {31'd0, dm_gnt}, 1);
    dm_req = 1'b0;
    tick();
    tick();
    check("fresh_valid", {31'd0, dm_valid}, 1);
    check("fresh_data",  {24'd0, dm_rdata}, 32'hA5);

    // READ_WAIT=0 and READ_WAIT=3 latency on 0x19
    req_w = 1'b1;
    tick();
    check("w_gnt", {30'd0, if_gnt_w0, if_gnt_w3}, 32'h3);
    req_w = 1'b0;
    tick();
    check("w0_valid", {31'd0, if_valid_w0}, 1);
    check("w0_data",  {24'd0, if_rdata_w0}, 32'hFF);
    check("w3_wait",  {30'd0, rd_w3, if_valid_w3}, 32'h2);
    tick();
    tick();
    check("w3_wait_last", {30'd0, rd_w3, if_valid_w3}, 32'h2);
    tick();
    check("w3_valid", {31'd0, if_valid_w3}, 1);
    check("w3_data",  {24'd0, if_rdata_w3}, 32'hFF);
    check("w3_rd_off", {31'd0, rd_w3}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
